// File: rtl/axi_pkg.sv
// Shared AXI4 types and constants for the subsystem.
// Contents: address/data/length/size/burst/response typedefs, the burst and
// response encodings in use, the 4-byte beat size, and a response-merge
// helper that keeps the first non-OKAY response seen in a transaction.
package axi_pkg;

   typedef logic [31:0] addr_t;
   typedef logic [7:0]  len_t;
   typedef logic [2:0]  size_t;
   typedef logic [1:0]  burst_t;
   typedef logic [31:0] data_t;
   typedef logic [1:0]  resp_t;

   localparam burst_t BURST_FIXED = 2'b00;
   localparam burst_t BURST_INCR  = 2'b01;

   localparam resp_t  RESP_OKAY   = 2'b00;
   localparam resp_t  RESP_SLVERR = 2'b10;

   localparam size_t  SIZE_4B     = 3'b010;

   // First non-OKAY response wins and is never overwritten.
   function automatic resp_t resp_merge(resp_t acc, resp_t incoming);
      return (acc == RESP_OKAY) ? incoming : acc;
   endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4 bus bundle (AR/R/AW/W/B) shared by masters and slaves.
// Ports: aclk, areset_n (same nets as the attached blocks' clock/reset).
// Modports: master drives AR/AW/W payloads+valids and R/B readys;
//           slave drives the complementary signals.
interface axi_if (
   input logic aclk,
   input logic areset_n
);
   import axi_pkg::*;

   addr_t  araddr;
   len_t   arlen;
   size_t  arsize;
   burst_t arburst;
   logic   arvalid;
   logic   arready;

   data_t  rdata;
   resp_t  rresp;
   logic   rlast;
   logic   rvalid;
   logic   rready;

   addr_t  awaddr;
   len_t   awlen;
   size_t  awsize;
   burst_t awburst;
   logic   awvalid;
   logic   awready;

   data_t  wdata;
   logic [3:0] wstrb;
   logic   wlast;
   logic   wvalid;
   logic   wready;

   resp_t  bresp;
   logic   bvalid;
   logic   bready;

   modport master (
      input  aclk, areset_n,
      output araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rdata, rresp, rlast, rvalid,
      output rready,
      output awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready
   );

   modport slave (
      input  aclk, areset_n,
      input  araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rdata, rresp, rlast, rvalid,
      input  rready,
      input  awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready
   );

endinterface

// File: rtl/axi_master_ctrl.sv
// Single-outstanding AXI4 burst master.
// Turns one local command at a time into an AXI read or write burst.
// Ports:
//   aclk, areset_n              clock, async active-low reset
//   cmd_*                       command request/accept (write, addr, len, burst)
//   wr_data/wr_valid/wr_ready   write beats from the local producer
//   rd_data/rd_valid/rd_ready/rd_last  read beats to the local consumer
//   done, done_resp             one-cycle completion pulse + worst response
//   m_axi                       AXI4 master modport
module axi_master_ctrl
   import axi_pkg::*;
#(
   parameter size_t       AXSIZE    = SIZE_4B,
   parameter int unsigned MAX_BEATS = 8
) (
   input  logic   aclk,
   input  logic   areset_n,
   input  logic   cmd_valid,
   output logic   cmd_ready,
   input  logic   cmd_write,
   input  addr_t  cmd_addr,
   input  len_t   cmd_len,
   input  burst_t cmd_burst,
   input  data_t  wr_data,
   input  logic   wr_valid,
   output logic   wr_ready,
   output data_t  rd_data,
   output logic   rd_valid,
   input  logic   rd_ready,
   output logic   rd_last,
   output logic   done,
   output resp_t  done_resp,
   axi_if.master  m_axi
);

   localparam int unsigned CW      = $clog2(MAX_BEATS) + 1;
   localparam len_t        LEN_MAX = len_t'(MAX_BEATS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_AR,
      S_R,
      S_AW,
      S_W,
      S_B,
      S_DONE
   } state_t;

   state_t          state, state_nxt;
   addr_t           addr_q;
   len_t            len_q;
   burst_t          burst_q;
   logic            write_q;
   logic [CW-1:0]   cnt;
   resp_t           resp_q;

   logic cmd_too_long;
   logic cnt_at_len;
   logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

   assign cmd_too_long = (cmd_len > LEN_MAX);
   assign cnt_at_len   = (len_t'(cnt) == len_q);

   assign ar_hs = (state == S_AR) && m_axi.arready;
   assign r_hs  = (state == S_R)  && m_axi.rvalid && rd_ready;
   assign aw_hs = (state == S_AW) && m_axi.awready;
   assign w_hs  = (state == S_W)  && wr_valid && m_axi.wready;
   assign b_hs  = (state == S_B)  && m_axi.bvalid;

   // State register
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Latched command, beat counter and response accumulator
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         addr_q  <= '0;
         len_q   <= '0;
         burst_q <= '0;
         write_q <= 1'b0;
         cnt     <= '0;
         resp_q  <= RESP_OKAY;
      end else begin
         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (cmd_valid) begin
                  addr_q  <= cmd_addr;
                  len_q   <= cmd_len;
                  burst_q <= cmd_burst;
                  write_q <= cmd_write;
                  // An illegal length completes as SLVERR without touching the bus.
                  resp_q  <= cmd_too_long ? RESP_SLVERR : RESP_OKAY;
               end
            end
            S_R: begin
               if (r_hs) begin
                  cnt    <= cnt + CW'(1);
                  resp_q <= resp_merge(resp_q, m_axi.rresp);
               end
            end
            S_W: begin
               if (w_hs) begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_B: begin
               if (b_hs) begin
                  resp_q <= resp_merge(resp_q, m_axi.bresp);
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               if (cmd_too_long) begin
                  state_nxt = S_DONE;
               end else if (cmd_write) begin
                  state_nxt = S_AW;
               end else begin
                  state_nxt = S_AR;
               end
            end
         end
         S_AR:   if (ar_hs) state_nxt = S_R;
         // A slave that signals rlast early ends the burst there.
         S_R:    if (r_hs && (m_axi.rlast || cnt_at_len)) state_nxt = S_DONE;
         S_AW:   if (aw_hs) state_nxt = S_W;
         S_W:    if (w_hs && cnt_at_len) state_nxt = S_B;
         S_B:    if (b_hs) state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs: valids depend only on state/latched data, never on the matching ready.
   always_comb begin
      cmd_ready = (state == S_IDLE);
      done      = (state == S_DONE);
      done_resp = (state == S_DONE) ? resp_q : RESP_OKAY;

      m_axi.araddr  = addr_q;
      m_axi.arlen   = len_q;
      m_axi.arsize  = AXSIZE;
      m_axi.arburst = burst_q;
      m_axi.arvalid = (state == S_AR);

      m_axi.awaddr  = addr_q;
      m_axi.awlen   = len_q;
      m_axi.awsize  = AXSIZE;
      m_axi.awburst = burst_q;
      m_axi.awvalid = (state == S_AW);

      m_axi.wdata   = wr_data;
      m_axi.wstrb   = '1;
      m_axi.wvalid  = (state == S_W) && wr_valid;
      m_axi.wlast   = (state == S_W) && cnt_at_len;
      wr_ready      = (state == S_W) && m_axi.wready;

      m_axi.rready  = (state == S_R) && rd_ready;
      rd_valid      = (state == S_R) && m_axi.rvalid;
      rd_data       = m_axi.rdata;
      rd_last       = (state == S_R) && m_axi.rlast;

      m_axi.bready  = (state == S_B);
   end

   // write_q is kept as part of the latched command for observability.
   logic unused_ok;
   assign unused_ok = write_q;

endmodule

// File: tb/tb_axi_master_ctrl.sv
// Self-checking bench for axi_master_ctrl: behavioural memory slave,
// write-data producer, read consumer with a ready pattern, and a transaction
// model (expected AR/AW/W/R beats and done responses) checked every cycle.
module tb_axi_master_ctrl;
   import axi_pkg::*;

   logic aclk = 1'b0;
   logic areset_n = 1'b0;
   always #5 aclk = ~aclk;

   axi_if axi (.aclk(aclk), .areset_n(areset_n));

   logic   cmd_valid, cmd_ready, cmd_write;
   addr_t  cmd_addr;
   len_t   cmd_len;
   burst_t cmd_burst;
   data_t  wr_data, rd_data;
   logic   wr_valid, wr_ready, rd_valid, rd_ready, rd_last, done;
   resp_t  done_resp;

   axi_master_ctrl #(.AXSIZE(SIZE_4B), .MAX_BEATS(8)) dut (
      .aclk(aclk), .areset_n(areset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_burst(cmd_burst),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
      .done(done), .done_resp(done_resp),
      .m_axi(axi)
   );

   int compared = 0;
   int mismatched = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction model ----------------
   typedef struct packed { data_t d; logic last; } beat_t;
   typedef struct packed { addr_t a; len_t l; burst_t b; } areq_t;

   data_t model_mem [64];
   data_t sl_mem    [64];
   beat_t exp_w[$];
   beat_t exp_r[$];
   areq_t exp_ar[$];
   areq_t exp_aw[$];
   resp_t exp_done[$];
   data_t wq[$];
   int    done_seen = 0;
   int    w_hs_cnt  = 0;
   resp_t last_resp = RESP_OKAY;

   int    err_rbeat  = -1;
   int    err_rbeat2 = -1;
   resp_t b_err_resp = RESP_OKAY;
   logic  rdy_pat [4] = '{1'b1, 1'b1, 1'b1, 1'b1};

   function automatic int idx(addr_t a, burst_t b, int beat);
      return ((int'(a >> 2)) + ((b == BURST_INCR) ? beat : 0)) & 63;
   endfunction

   function automatic resp_t slave_rresp(int beat);
      if (beat == err_rbeat)  return RESP_SLVERR;
      if (beat == err_rbeat2) return 2'b11;
      return RESP_OKAY;
   endfunction

   // ---------------- behavioural slave ----------------
   int     rd_act, rd_beat, rd_len, wr_act, wr_beat;
   addr_t  rd_addr, wr_addr;
   burst_t rd_burst, wr_burst;

   task automatic slave_reset();
      rd_act = 0; wr_act = 0; rd_beat = 0; wr_beat = 0;
      axi.arready = 0; axi.awready = 0; axi.wready = 0;
      axi.rvalid = 0; axi.rdata = '0; axi.rlast = 0; axi.rresp = RESP_OKAY;
      axi.bvalid = 0; axi.bresp = RESP_OKAY;
   endtask

   initial begin : slave
      logic s_ar, s_aw, s_r, s_w, s_wl, s_b, s_arv, s_awv;
      data_t s_wd;
      addr_t s_ara, s_awa;
      len_t s_arl, s_awl;
      burst_t s_arb, s_awb;
      slave_reset();
      forever begin
         @(negedge aclk);
         s_ar = axi.arvalid && axi.arready;  s_arv = axi.arvalid;
         s_aw = axi.awvalid && axi.awready;  s_awv = axi.awvalid;
         s_r  = axi.rvalid && axi.rready;
         s_w  = axi.wvalid && axi.wready;    s_wl = axi.wlast; s_wd = axi.wdata;
         s_b  = axi.bvalid && axi.bready;
         s_ara = axi.araddr; s_arl = axi.arlen; s_arb = axi.arburst;
         s_awa = axi.awaddr; s_awl = axi.awlen; s_awb = axi.awburst;
         @(posedge aclk);
         #1;
         if (!areset_n) begin
            slave_reset();
            continue;
         end
         // read side, ready given one cycle after arvalid is seen
         if (s_ar) begin
            rd_act = 1; rd_addr = s_ara; rd_len = int'(s_arl); rd_burst = s_arb; rd_beat = 0;
            axi.arready = 0;
         end else if (s_arv && rd_act == 0) begin
            axi.arready = 1;
         end
         if (s_r) begin
            rd_beat++;
            if (rd_beat > rd_len) rd_act = 0;
         end
         axi.rvalid = (rd_act != 0);
         if (rd_act != 0) begin
            axi.rdata = sl_mem[idx(rd_addr, rd_burst, rd_beat)];
            axi.rlast = (rd_beat == rd_len);
            axi.rresp = slave_rresp(rd_beat);
         end else begin
            axi.rlast = 0;
         end
         // write side
         if (s_aw) begin
            wr_act = 1; wr_addr = s_awa; wr_burst = s_awb; wr_beat = 0;
            axi.awready = 0;
         end else if (s_awv && wr_act == 0) begin
            axi.awready = 1;
         end
         if (s_b) axi.bvalid = 0;
         if (s_w) begin
            sl_mem[idx(wr_addr, wr_burst, wr_beat)] = s_wd;
            wr_beat++;
            if (s_wl) begin
               wr_act = 0;
               axi.bvalid = 1;
               axi.bresp = b_err_resp;
            end
         end
         axi.wready = (wr_act != 0);
      end
   end

   // ---------------- write producer and read consumer ----------------
   initial begin : producer
      logic p_hs;
      wr_valid = 0; wr_data = '0;
      forever begin
         @(negedge aclk);
         p_hs = wr_valid && wr_ready;
         @(posedge aclk);
         #1;
         if (p_hs && wq.size() > 0) void'(wq.pop_front());
         wr_valid = (wq.size() > 0);
         wr_data  = (wq.size() > 0) ? wq[0] : '0;
      end
   end

   initial begin : consumer
      int k = 0;
      rd_ready = 1;
      forever begin
         @(posedge aclk);
         #1;
         rd_ready = rdy_pat[k % 4];
         k++;
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin : compare
      logic prev_done = 0, prev_arwait = 0, prev_awwait = 0;
      addr_t prev_araddr = '0, prev_awaddr = '0;
      beat_t b;
      areq_t q;
      forever begin
         @(negedge aclk);
         if (!areset_n) begin
            prev_done = 0; prev_arwait = 0; prev_awwait = 0;
            continue;
         end
         if (prev_arwait) begin
            check("arvalid_hold", axi.arvalid, 1);
            check("araddr_hold", axi.araddr, prev_araddr);
         end
         if (prev_awwait) begin
            check("awvalid_hold", axi.awvalid, 1);
            check("awaddr_hold", axi.awaddr, prev_awaddr);
         end
         prev_arwait = axi.arvalid && !axi.arready; prev_araddr = axi.araddr;
         prev_awwait = axi.awvalid && !axi.awready; prev_awaddr = axi.awaddr;

         if (axi.arvalid && axi.arready) begin
            check("ar_expected", exp_ar.size() > 0, 1);
            if (exp_ar.size() > 0) begin
               q = exp_ar.pop_front();
               check("araddr", axi.araddr, q.a);
               check("arlen", axi.arlen, q.l);
               check("arburst", axi.arburst, q.b);
               check("arsize", axi.arsize, 3'b010);
            end
         end
         if (axi.awvalid && axi.awready) begin
            check("aw_expected", exp_aw.size() > 0, 1);
            if (exp_aw.size() > 0) begin
               q = exp_aw.pop_front();
               check("awaddr", axi.awaddr, q.a);
               check("awlen", axi.awlen, q.l);
               check("awburst", axi.awburst, q.b);
               check("awsize", axi.awsize, 3'b010);
            end
         end
         if (axi.wvalid && axi.wready) begin
            w_hs_cnt++;
            check("w_expected", exp_w.size() > 0, 1);
            if (exp_w.size() > 0) begin
               b = exp_w.pop_front();
               check("wdata", axi.wdata, b.d);
               check("wlast", axi.wlast, b.last);
            end
         end
         if (rd_valid && rd_ready) begin
            check("r_expected", exp_r.size() > 0, 1);
            if (exp_r.size() > 0) begin
               b = exp_r.pop_front();
               check("rd_data", rd_data, b.d);
               check("rd_last", rd_last, b.last);
            end
         end
         check("rd_valid_mirror", rd_valid, axi.rvalid);
         if (axi.rready) check("rready_needs_rd_ready", rd_ready, 1);
         if (prev_done) check("cmd_ready_after_done", cmd_ready, 1);
         if (done) begin
            check("done_one_cycle", prev_done, 0);
            check("done_expected", exp_done.size() > 0, 1);
            if (exp_done.size() > 0) check("done_resp", done_resp, exp_done.pop_front());
            last_resp = done_resp;
            done_seen++;
         end
         prev_done = done;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_cmd(logic wr, addr_t a, len_t l, burst_t bt);
      logic acc = 0;
      @(posedge aclk);
      #1;
      cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_burst = bt;
      for (int i = 0; i < 50; i++) begin
         @(negedge aclk);
         if (cmd_ready) begin acc = 1; break; end
      end
      if (!acc) check("cmd_accept_bound", cmd_ready, 1);
      @(posedge aclk);
      #1;
      cmd_valid = 0;
   endtask

   task automatic wait_done();
      int start = done_seen;
      for (int i = 0; i < 200; i++) begin
         @(posedge aclk);
         if (done_seen > start) break;
      end
      if (done_seen <= start) check("done_within_bound", done_seen > start, 1);
      #1;
   endtask

   task automatic push_write(addr_t a, len_t l, burst_t bt, data_t base, logic upd_model);
      exp_aw.push_back('{a: a, l: l, b: bt});
      for (int i = 0; i <= int'(l); i++) begin
         exp_w.push_back('{d: base + data_t'(i), last: (i == int'(l))});
         wq.push_back(base + data_t'(i));
         if (upd_model) model_mem[idx(a, bt, i)] = base + data_t'(i);
      end
   endtask

   task automatic do_write(addr_t a, len_t l, burst_t bt, data_t base);
      push_write(a, l, bt, base, 1);
      exp_done.push_back(b_err_resp);
      send_cmd(1, a, l, bt);
      wait_done();
   endtask

   task automatic do_read(addr_t a, len_t l, burst_t bt);
      resp_t worst = RESP_OKAY;
      exp_ar.push_back('{a: a, l: l, b: bt});
      for (int i = 0; i <= int'(l); i++) begin
         exp_r.push_back('{d: model_mem[idx(a, bt, i)], last: (i == int'(l))});
         if (worst == RESP_OKAY) worst = slave_rresp(i);
      end
      exp_done.push_back(worst);
      send_cmd(0, a, l, bt);
      wait_done();
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed tests ----------------
   initial begin : stim
      int start;
      cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_burst = BURST_INCR;
      for (int i = 0; i < 64; i++) begin model_mem[i] = '0; sl_mem[i] = '0; end

      // reset values while asserted and in the first cycle after release
      repeat (2) @(negedge aclk);
      check("rst_arvalid", axi.arvalid, 0);
      check("rst_awvalid", axi.awvalid, 0);
      check("rst_done", done, 0);
      @(posedge aclk); #1; areset_n = 1;
      @(negedge aclk);
      check("post_rst_cmd_ready", cmd_ready, 1);
      check("post_rst_wvalid", axi.wvalid, 0);
      check("post_rst_wlast", axi.wlast, 0);
      check("post_rst_bready", axi.bready, 0);
      check("post_rst_rready", axi.rready, 0);
      check("post_rst_done_resp", done_resp, RESP_OKAY);

      // 1: 4-beat INCR write then read back
      do_write(32'd2, 8'd3, BURST_INCR, 32'hA0);
      check("t1_w_resp", last_resp, RESP_OKAY);
      do_read(32'd2, 8'd3, BURST_INCR);
      check("t1_r_resp", last_resp, RESP_OKAY);
      check("t1_mem3", sl_mem[3], 32'hA3);

      // 2: single beat
      do_write(32'd0, 8'd0, BURST_INCR, 32'h5A);
      do_read(32'd0, 8'd0, BURST_INCR);
      check("t2_mem0", sl_mem[0], 32'h5A);

      // 3: consumer stalls with ready pattern 1,0,0,1
      rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      do_write(32'd0, 8'd3, BURST_INCR, 32'hB0);
      do_read(32'd0, 8'd3, BURST_INCR);
      rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b1};

      // FIXED bursts hit one location repeatedly
      do_write(32'd32, 8'd2, BURST_FIXED, 32'hD0);
      check("fixed_mem8", sl_mem[8], 32'hD2);
      do_read(32'd32, 8'd1, BURST_FIXED);

      // 4: illegal length -> SLVERR, no bus activity
      exp_done.push_back(RESP_SLVERR);
      send_cmd(1, 32'd4, 8'd8, BURST_INCR);
      @(negedge aclk);
      check("t4_done_next_cycle", done, 1);
      check("t4_resp", done_resp, RESP_SLVERR);
      for (int i = 0; i < 4; i++) begin
         check("t4_no_awvalid", axi.awvalid, 0);
         check("t4_no_arvalid", axi.arvalid, 0);
         @(negedge aclk);
      end

      // 5: read error on beat 1 (then DECERR on beat 2) -> first error sticks
      err_rbeat = 1; err_rbeat2 = 2;
      do_read(32'd2, 8'd3, BURST_INCR);
      check("t5_resp", last_resp, RESP_SLVERR);
      err_rbeat = -1; err_rbeat2 = -1;
      b_err_resp = RESP_SLVERR;
      do_write(32'd16, 8'd1, BURST_INCR, 32'hE0);
      check("t5_bresp", last_resp, RESP_SLVERR);
      b_err_resp = RESP_OKAY;

      // 6: reset during W after two beats, then recover
      start = w_hs_cnt;
      push_write(32'd40, 8'd5, BURST_INCR, 32'hF0, 0);
      send_cmd(1, 32'd40, 8'd5, BURST_INCR);
      for (int i = 0; i < 50; i++) begin
         @(posedge aclk);
         if (w_hs_cnt >= start + 2) break;
      end
      check("t6_two_beats", w_hs_cnt - start, 2);
      #3;
      areset_n = 0;
      #1;
      check("t6_wvalid", axi.wvalid, 0);
      check("t6_wlast", axi.wlast, 0);
      check("t6_awvalid", axi.awvalid, 0);
      check("t6_arvalid", axi.arvalid, 0);
      check("t6_rready", axi.rready, 0);
      check("t6_bready", axi.bready, 0);
      check("t6_done", done, 0);
      check("t6_wr_ready", wr_ready, 0);
      exp_w.delete(); exp_aw.delete(); wq.delete();
      repeat (2) @(posedge aclk);
      #1;
      areset_n = 1;
      @(negedge aclk);
      check("t6_cmd_ready", cmd_ready, 1);
      do_write(32'd8, 8'd3, BURST_INCR, 32'hC0);
      do_read(32'd8, 8'd3, BURST_INCR);
      check("t6_resp", last_resp, RESP_OKAY);

      repeat (5) @(posedge aclk);
      check("drain_w", exp_w.size(), 0);
      check("drain_r", exp_r.size(), 0);
      check("drain_done", exp_done.size(), 0);
      check("drain_ar", exp_ar.size(), 0);
      check("drain_aw", exp_aw.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
